// File: rtl/user_io_pkg.sv
// Shared types and default constants for the user output stretcher.
package user_io_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam int unsigned DEF_HOLD_CYCLES = 4;
    localparam int unsigned DEF_GAP_CYCLES  = 2;
    localparam int unsigned DEF_PEND_W      = 2;

    // Larger of two unsigned values, used to size the shared timer.
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hold_timer.sv
// Loadable down-counter that saturates at zero; zero flag is registered.
module hold_timer #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] count_q, count_d;
    logic         zero_q, zero_d;

    // Load takes priority; counting stops at zero instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
        zero_d = (count_d == '0);
    end

    // Counter and zero flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            zero_q  <= 1'b1;
        end else begin
            count_q <= count_d;
            zero_q  <= zero_d;
        end
    end

    assign zero = zero_q;

endmodule

// File: rtl/user_output.sv
// Pulse stretcher for a human-visible output: each event becomes a fixed
// high window followed by a minimum low gap; extra events queue in a
// saturating pending counter.
module user_output
    import user_io_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES,
    parameter int unsigned PEND_W      = DEF_PEND_W
) (
    input  logic clk,
    input  logic rst,
    input  logic pulse_in,
    output logic level_out,
    output logic busy,
    output logic overflow
);

    localparam int unsigned TMR_W    = $clog2(max_u(HOLD_CYCLES, GAP_CYCLES) + 1);
    localparam int unsigned PEND_MAX = (32'd1 << PEND_W) - 32'd1;
    localparam logic [TMR_W-1:0]  HOLD_LD  = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0]  GAP_LD   = TMR_W'(GAP_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_TOP = PEND_W'(PEND_MAX);

    state_e              state_q, state_d;
    logic [PEND_W-1:0]   pending_q, pending_d;
    logic                level_q, level_d;
    logic                busy_q, busy_d;
    logic                overflow_q, overflow_d;

    logic                tmr_load;
    logic [TMR_W-1:0]    tmr_val;
    logic                tmr_en;
    logic                tmr_zero;
    logic                accept_cand;
    logic                accept;
    logic                consume_pend;
    logic                consume_direct;

    hold_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .zero     (tmr_zero)
    );

    // Next state, timer control, event queueing and overflow detection.
    always_comb begin
        state_d        = state_q;
        tmr_load       = 1'b0;
        tmr_val        = '0;
        consume_pend   = 1'b0;
        consume_direct = 1'b0;
        accept_cand    = 1'b0;

        case (state_q)
            IDLE: begin
                if (pulse_in) begin
                    state_d  = HOLD;
                    tmr_load = 1'b1;
                    tmr_val  = HOLD_LD;
                end
            end
            HOLD: begin
                accept_cand = pulse_in;
                if (tmr_zero) begin
                    state_d  = GAP;
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LD;
                end
            end
            GAP: begin
                if (tmr_zero && ((pending_q != '0) || pulse_in)) begin
                    state_d  = HOLD;
                    tmr_load = 1'b1;
                    tmr_val  = HOLD_LD;
                    if (pending_q != '0) begin
                        consume_pend = 1'b1;
                    end else begin
                        consume_direct = 1'b1;
                    end
                end else if (tmr_zero) begin
                    state_d = IDLE;
                end
                accept_cand = pulse_in && !consume_direct;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A consume on the same cycle frees a slot, so a full queue still accepts.
        accept     = accept_cand && ((pending_q != PEND_TOP) || consume_pend);
        overflow_d = accept_cand && !accept;
        pending_d  = pending_q + PEND_W'(accept) - PEND_W'(consume_pend);

        level_d = (state_d == HOLD);
        busy_d  = (state_d != IDLE);
    end

    assign tmr_en = (state_q == HOLD) || (state_q == GAP);

    // State, queue and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            level_q    <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            level_q    <= level_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
        end
    end

    assign level_out = level_q;
    assign busy      = busy_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_user_output.sv
// Directed bench for user_output with default parameters (4 / 2 / 2).
module tb_user_output;

    logic clk;
    logic rst;
    logic pulse_in;
    logic level_out;
    logic busy;
    logic overflow;

    int n_cmp = 0;
    int n_err = 0;

    user_output dut (
        .clk       (clk),
        .rst       (rst),
        .pulse_in  (pulse_in),
        .level_out (level_out),
        .busy      (busy),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bit i of each vector is the pulse driven before edge i and the
    // output expected just after that edge.
    task automatic run_seq(input string tag, input int n, input logic [31:0] p,
                           input logic [31:0] l, input logic [31:0] b, input logic [31:0] o);
        for (int i = 0; i < n; i++) begin
            pulse_in = p[i];
            tick();
            chk($sformatf("%s.lvl[%0d]", tag, i), 32'(level_out), 32'(l[i]));
            chk($sformatf("%s.busy[%0d]", tag, i), 32'(busy), 32'(b[i]));
            chk($sformatf("%s.ovf[%0d]", tag, i), 32'(overflow), 32'(o[i]));
        end
        pulse_in = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        pulse_in = 1'b0;
        #1;
        chk("rst0.lvl", 32'(level_out), 32'd0);
        chk("rst0.busy", 32'(busy), 32'd0);
        chk("rst0.ovf", 32'(overflow), 32'd0);
        run_seq("rst", 2, 32'h0, 32'h0, 32'h0, 32'h0);
        rst = 1'b0;

        // Single pulse on the first edge after reset release.
        run_seq("single", 8, 32'h1, 32'h0F, 32'h3F, 32'h0);

        // Second pulse two cycles later queues one window.
        run_seq("two", 14, 32'h5, 32'h3CF, 32'hFFF, 32'h0);

        // Five back-to-back pulses: queue saturates at 3, fifth overflows.
        run_seq("five", 26, 32'h1F, 32'h3CF3CF, 32'hFFFFFF, 32'h10);
        chk("five.pend", 32'(dut.pending_q), 32'd0);

        // Full queue plus pulse on final GAP cycle: no overflow, queue stays full.
        run_seq("fullgap_a", 7, 32'h4F, 32'h4F, 32'h7F, 32'h0);
        chk("fullgap.pend", 32'(dut.pending_q), 32'd3);
        run_seq("fullgap_b", 25, 32'h0, 32'h1E79E7, 32'h7FFFFF, 32'h0);
        chk("fullgap.pend_end", 32'(dut.pending_q), 32'd0);

        // Asynchronous reset in HOLD with two queued events.
        run_seq("pre_rst", 3, 32'h7, 32'h7, 32'h7, 32'h0);
        chk("pre_rst.pend", 32'(dut.pending_q), 32'd2);
        #3;
        rst = 1'b1;
        #1;
        chk("async.lvl", 32'(level_out), 32'd0);
        chk("async.busy", 32'(busy), 32'd0);
        chk("async.ovf", 32'(overflow), 32'd0);
        chk("async.pend", 32'(dut.pending_q), 32'd0);
        tick();
        rst = 1'b0;
        run_seq("post_rst", 10, 32'h0, 32'h0, 32'h0, 32'h0);

        // Normal operation resumes after the reset.
        run_seq("resume", 8, 32'h1, 32'h0F, 32'h3F, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
